painter_hue_stripe_gen: RTL and testbench

//  Parametrised pipelined pixel painter: maps (frame, x, y) to packed RGB hue-wheel stripes, dimmed by a

---
 rtl/painter_hue_stripe_gen_if.sv | 30 +++
 rtl/painter_hue_stripe_gen.sv | 189 ++++++++++++++++++
 tb/tb_painter_hue_stripe_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/painter_hue_stripe_gen_if.sv
// rtl/painter_hue_stripe_gen_if.sv - pixel request, mode and rgb bundle for the hue stripe painter
interface painter_hue_stripe_gen_if #(
  parameter int FRAME_BITS = 16,
  parameter int X_BITS     = 6,
  parameter int Y_BITS     = 6,
  parameter int CHAN_BITS  = 8
);
  logic [FRAME_BITS-1:0]  frame;
  logic                   frame_start;
  logic                   in_valid;
  logic [X_BITS-1:0]      x;
  logic [Y_BITS-1:0]      y;
  logic [1:0]             mode_req;
  logic                   mode_req_vld;
  logic [1:0]             mode;
  logic                   out_valid;
  logic [3*CHAN_BITS-1:0] rgb;

  // Scanner side: issues pixel requests and mode changes, receives colours.
  modport master (
    output frame, frame_start, in_valid, x, y, mode_req, mode_req_vld,
    input  mode, out_valid, rgb
  );

  // Painter side.
  modport slave (
    input  frame, frame_start, in_valid, x, y, mode_req, mode_req_vld,
    output mode, out_valid, rgb
  );
endinterface

// File: rtl/painter_hue_stripe_gen.sv
// rtl/painter_hue_stripe_gen.sv - pipelined hue-wheel stripe painter; optional fade stage via PAINTER_FADE_EN
module painter_hue_stripe_gen #(
  parameter int FRAME_BITS  = 16,
  parameter int X_BITS      = 6,
  parameter int Y_BITS      = 6,
  parameter int CHAN_BITS   = 8,
  parameter int STRIPE_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  painter_hue_stripe_gen_if.slave bus
);
  localparam int D        = Y_BITS - 1;
  localparam int HUE_BITS = Y_BITS + 2;
  localparam int CW       = CHAN_BITS;

  localparam logic [1:0] MODE_STRIPES = 2'd0;
  localparam logic [1:0] MODE_SOLID   = 2'd1;
  localparam logic [1:0] MODE_MONO    = 2'd2;

  // Widen a D-bit intensity to a channel by repeating its bits MSB first.
  function automatic logic [CW-1:0] scale_chan(input logic [D-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int k = 0; k < CW; k++) r[CW-1-k] = v[D-1-(k % D)];
    return r;
  endfunction

  // Upper frame bits only feed the pixel maths partially.
  logic unused_frame_bits;
  assign unused_frame_bits = ^bus.frame;

  // Mode control
  logic [1:0] mode_q, mode_d, pend_q, pend_d;

  // S1
  logic                v1_q, v1_d, st1_q, st1_d;
  logic [HUE_BITS-1:0] hue1_q, hue1_d;
  logic [Y_BITS-1:0]   yy1_q, yy1_d;
  logic [1:0]          md1_q, md1_d;
  logic [STRIPE_LOG2-1:0] sdiff;
  // S2
  logic                v2_q, v2_d, st2_q, st2_d;
  logic [HUE_BITS-1:0] hue2_q, hue2_d;
  logic [D-1:0]        dim2_q, dim2_d;
  logic [1:0]          md2_q, md2_d;
  // S3
  logic                v3_q, v3_d, st3_q, st3_d, up;
  logic [2:0]          sol3_q, sol3_d, grd3_q, grd3_d, sector;
  logic [D-1:0]        gd3_q, gd3_d, dim3_q, dim3_d, f;
  logic [1:0]          md3_q, md3_d;
  // S4
  logic                v4_q, v4_d;
  logic [3*CW-1:0]     rgb4_q, rgb4_d, col;
  logic [D-1:0]        ss, gg;
  logic [CW-1:0]       ss_c, gg_c;

`ifdef PAINTER_FADE_EN
  logic [3:0]          fade_q, fade_d, fd1_q, fd2_q, fd3_q, fd4_q;
  logic                v5_q;
  logic [3*CW-1:0]     rgb5_q, rgb5_d;
`endif

  // Pending request and frame-synchronous mode switch.
  always_comb begin
    mode_d = mode_q;
    pend_d = pend_q;
    if (bus.frame_start)  mode_d = pend_q;
    if (bus.mode_req_vld) pend_d = bus.mode_req;
  end

  // Pixel datapath next-state, one section per stage.
  always_comb begin
    // S1: hue, diagonal coordinate, stripe phase; mode latched with the pixel
    v1_d   = bus.in_valid;
    hue1_d = bus.frame[2 +: HUE_BITS] - HUE_BITS'(bus.x >> 1);
    yy1_d  = bus.y + bus.frame[0 +: Y_BITS] + Y_BITS'(bus.x);
    sdiff  = bus.x[STRIPE_LOG2-1:0] - bus.frame[STRIPE_LOG2-1:0];
    st1_d  = |sdiff;
    md1_d  = mode_d;

    // S2: fold the diagonal into a triangle wave
    v2_d   = v1_q;
    hue2_d = hue1_q;
    st2_d  = st1_q;
    md2_d  = md1_q;
    dim2_d = yy1_q[Y_BITS-1] ? ~yy1_q[D-1:0] : yy1_q[D-1:0];

    // S3: hue sector decode (bit0 R, bit1 G, bit2 B)
    sector = hue2_q[HUE_BITS-1 -: 3];
    f      = hue2_q[D-1:0];
    sol3_d = 3'b000;
    grd3_d = 3'b001;
    up     = 1'b1;
    case (sector)
      3'd0: begin sol3_d = 3'b000; grd3_d = 3'b001; up = 1'b1; end
      3'd1: begin sol3_d = 3'b001; grd3_d = 3'b010; up = 1'b1; end
      3'd2: begin sol3_d = 3'b010; grd3_d = 3'b001; up = 1'b0; end
      3'd3: begin sol3_d = 3'b010; grd3_d = 3'b100; up = 1'b1; end
      3'd4: begin sol3_d = 3'b110; grd3_d = 3'b001; up = 1'b1; end
      3'd5: begin sol3_d = 3'b101; grd3_d = 3'b010; up = 1'b0; end
      3'd6: begin sol3_d = 3'b100; grd3_d = 3'b001; up = 1'b0; end
      3'd7: begin sol3_d = 3'b000; grd3_d = 3'b100; up = 1'b0; end
    endcase
    gd3_d  = up ? f : ~f;
    dim3_d = dim2_q;
    v3_d   = v2_q;
    st3_d  = st2_q;
    md3_d  = md2_q;

    // S4: dim, scale, assemble channels and apply the mode
    v4_d = v3_q;
    ss   = ~dim3_q;
    gg   = (gd3_q > dim3_q) ? (gd3_q - dim3_q) : '0;
    ss_c = scale_chan(ss);
    gg_c = scale_chan(gg);
    col  = '0;
    for (int c = 0; c < 3; c++) begin
      if (grd3_q[c])      col[c*CW +: CW] = gg_c;
      else if (sol3_q[c]) col[c*CW +: CW] = ss_c;
    end
    case (md3_q)
      MODE_STRIPES: rgb4_d = st3_q ? col : '0;
      MODE_SOLID:   rgb4_d = col;
      MODE_MONO:    rgb4_d = st3_q ? {3{ss_c}} : '0;
      default:      rgb4_d = '0;
    endcase
  end

  // Mode and pipeline registers; async reset flushes pixels in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= '0;  pend_q <= '0;
      v1_q <= 1'b0;  st1_q <= 1'b0; hue1_q <= '0; yy1_q <= '0; md1_q <= '0;
      v2_q <= 1'b0;  st2_q <= 1'b0; hue2_q <= '0; dim2_q <= '0; md2_q <= '0;
      v3_q <= 1'b0;  st3_q <= 1'b0; sol3_q <= '0; grd3_q <= '0;
      gd3_q <= '0;   dim3_q <= '0;  md3_q <= '0;
      v4_q <= 1'b0;  rgb4_q <= '0;
    end else begin
      mode_q <= mode_d; pend_q <= pend_d;
      v1_q <= v1_d;  st1_q <= st1_d; hue1_q <= hue1_d; yy1_q <= yy1_d; md1_q <= md1_d;
      v2_q <= v2_d;  st2_q <= st2_d; hue2_q <= hue2_d; dim2_q <= dim2_d; md2_q <= md2_d;
      v3_q <= v3_d;  st3_q <= st3_d; sol3_q <= sol3_d; grd3_q <= grd3_d;
      gd3_q <= gd3_d; dim3_q <= dim3_d; md3_q <= md3_d;
      v4_q <= v4_d;  rgb4_q <= rgb4_d;
    end
  end

`ifdef PAINTER_FADE_EN
  // Fade ramps once per frame and restarts whenever a different mode is applied.
  always_comb begin
    fade_d = fade_q;
    if (bus.frame_start) begin
      if (pend_q != mode_q)    fade_d = '0;
      else if (fade_q != 4'hF) fade_d = fade_q + 4'd1;
    end
  end

  // S5: scale each channel by (fade+1)/16.
  always_comb begin
    logic [CW+3:0] prod;
    rgb5_d = '0;
    for (int c = 0; c < 3; c++) begin
      prod = (CW+4)'(rgb4_q[c*CW +: CW]) * (CW+4)'({1'b0, fd4_q} + 5'd1);
      rgb5_d[c*CW +: CW] = CW'(prod >> 4);
    end
  end

  // Fade register, its per-pixel copy down the pipe, and the S5 output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fade_q <= '0; fd1_q <= '0; fd2_q <= '0; fd3_q <= '0; fd4_q <= '0;
      v5_q   <= 1'b0; rgb5_q <= '0;
    end else begin
      fade_q <= fade_d;
      fd1_q  <= fade_d; fd2_q <= fd1_q; fd3_q <= fd2_q; fd4_q <= fd3_q;
      v5_q   <= v4_q;   rgb5_q <= rgb5_d;
    end
  end

  assign bus.out_valid = v5_q;
  assign bus.rgb       = rgb5_q;
`else
  assign bus.out_valid = v4_q;
  assign bus.rgb       = rgb4_q;
`endif

  assign bus.mode = mode_q;
endmodule

// File: tb/tb_painter_hue_stripe_gen.sv
// tb/tb_painter_hue_stripe_gen.sv - directed self-checking bench for painter_hue_stripe_gen (default build)
module tb_painter_hue_stripe_gen;
  localparam int LAT = 4;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  painter_hue_stripe_gen_if bus ();

  painter_hue_stripe_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.frame = '0; bus.frame_start = 1'b0; bus.in_valid = 1'b0;
    bus.x = '0; bus.y = '0; bus.mode_req = '0; bus.mode_req_vld = 1'b0;
  endtask

  // Issue one pixel, wait the pipeline latency, return what appears.
  task automatic run_pixel(input logic [15:0] f, input logic [5:0] px, input logic [5:0] py,
                           output logic [23:0] rgb_o, output logic vld_o, output logic early_o);
    bus.frame = f; bus.x = px; bus.y = py; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    early_o = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      early_o = early_o | bus.out_valid;
      step();
    end
    rgb_o = bus.rgb;
    vld_o = bus.out_valid;
  endtask

  task automatic req_mode(input logic [1:0] m);
    bus.mode_req = m; bus.mode_req_vld = 1'b1;
    step();
    bus.mode_req_vld = 1'b0;
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    tests_run++;
    if (bus.rgb !== 24'h0) begin tests_failed++; $display("FAIL reset_rgb: got %h expected 000000", bus.rgb); end
    tests_run++;
    if (bus.mode !== 2'd0) begin tests_failed++; $display("FAIL reset_mode: got %0d expected 0", bus.mode); end
  endtask

  task automatic test_latency();
    logic [23:0] r; logic v, e;
    run_pixel(16'h0000, 6'd0, 6'd0, r, v, e);
    tests_run++;
    if (e !== 1'b0) begin tests_failed++; $display("FAIL lat_early: got %b expected 0", e); end
    tests_run++;
    if (v !== 1'b1) begin tests_failed++; $display("FAIL lat_valid: got %b expected 1", v); end
    tests_run++;
    if (r !== 24'h000000) begin tests_failed++; $display("FAIL lat_rgb: got %h expected 000000", r); end
    step();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_single: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_stripes();
    logic [23:0] r; logic v, e;
    run_pixel(16'h0080, 6'd1, 6'd0, r, v, e);
    tests_run++;
    if (r !== 24'h0000F7) begin tests_failed++; $display("FAIL stripe_f7: got %h expected 0000f7", r); end
    run_pixel(16'h0080, 6'd0, 6'd0, r, v, e);
    tests_run++;
    if (r !== 24'h000000) begin tests_failed++; $display("FAIL stripe_masked: got %h expected 000000", r); end
    run_pixel(16'h0100, 6'd3, 6'd2, r, v, e);
    tests_run++;
    if (r !== 24'h00D6D6) begin tests_failed++; $display("FAIL stripe_sector1: got %h expected 00d6d6", r); end
    run_pixel(16'h0280, 6'd6, 6'd0, r, v, e);
    tests_run++;
    if (r !== 24'hCECEBD) begin tests_failed++; $display("FAIL stripe_sector4: got %h expected cecebd", r); end
  endtask

  task automatic test_mode_handshake();
    logic [23:0] r; logic v, e;
    req_mode(2'd1);
    tests_run++;
    if (bus.mode !== 2'd0) begin tests_failed++; $display("FAIL mode_pending_hold: got %0d expected 0", bus.mode); end
    run_pixel(16'h0080, 6'd0, 6'd0, r, v, e);
    tests_run++;
    if (r !== 24'h000000) begin tests_failed++; $display("FAIL mode_before_fs: got %h expected 000000", r); end
    pulse_fs();
    tests_run++;
    if (bus.mode !== 2'd1) begin tests_failed++; $display("FAIL mode_after_fs: got %0d expected 1", bus.mode); end
    run_pixel(16'h0080, 6'd0, 6'd0, r, v, e);
    tests_run++;
    if (r !== 24'h0000FF) begin tests_failed++; $display("FAIL solid_ff: got %h expected 0000ff", r); end
    run_pixel(16'h0080, 6'd0, 6'd33, r, v, e);
    tests_run++;
    if (r !== 24'h000008) begin tests_failed++; $display("FAIL solid_dim30: got %h expected 000008", r); end
  endtask

  task automatic test_back_to_back();
    logic pat [17];
    int   idx;
    logic expv;
    for (int i = 0; i < 17; i++) pat[i] = !(i == 10 || i == 11);
    bus.frame = 16'h0080; bus.x = 6'd0;
    for (int s = 0; s < 17 + LAT; s++) begin
      if (s < 17) begin
        bus.in_valid = pat[s];
        bus.y = (s % 2 == 1) ? 6'd33 : 6'd0;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      idx = s - (LAT - 1);
      expv = (idx >= 0 && idx < 17) ? pat[idx] : 1'b0;
      tests_run++;
      if (bus.out_valid !== expv) begin
        tests_failed++; $display("FAIL b2b_valid[%0d]: got %b expected %b", s, bus.out_valid, expv);
      end
      if (expv) begin
        tests_run++;
        if (bus.rgb !== ((idx % 2 == 1) ? 24'h000008 : 24'h0000FF)) begin
          tests_failed++; $display("FAIL b2b_rgb[%0d]: got %h expected %h", s, bus.rgb,
                                   (idx % 2 == 1) ? 24'h000008 : 24'h0000FF);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [23:0] r; logic v, e;
    req_mode(2'd3);
    bus.mode_req = 2'd0; bus.mode_req_vld = 1'b1; bus.frame_start = 1'b1;
    bus.frame = 16'h0080; bus.x = 6'd0; bus.y = 6'd0; bus.in_valid = 1'b1;
    step();
    bus.mode_req_vld = 1'b0; bus.frame_start = 1'b0; bus.in_valid = 1'b0;
    tests_run++;
    if (bus.mode !== 2'd3) begin tests_failed++; $display("FAIL same_cycle_mode: got %0d expected 3", bus.mode); end
    for (int k = 1; k < LAT; k++) step();
    tests_run++;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL off_valid: got %b expected 1", bus.out_valid); end
    tests_run++;
    if (bus.rgb !== 24'h000000) begin tests_failed++; $display("FAIL off_rgb_fs_pixel: got %h expected 000000", bus.rgb); end
    pulse_fs();
    tests_run++;
    if (bus.mode !== 2'd0) begin tests_failed++; $display("FAIL same_cycle_next: got %0d expected 0", bus.mode); end
    req_mode(2'd2);
    req_mode(2'd1);
    pulse_fs();
    tests_run++;
    if (bus.mode !== 2'd1) begin tests_failed++; $display("FAIL last_req_wins: got %0d expected 1", bus.mode); end
    run_pixel(16'h0100, 6'd3, 6'd2, r, v, e);
    tests_run++;
    if (r !== 24'h00D6D6) begin tests_failed++; $display("FAIL solid_sector1: got %h expected 00d6d6", r); end
    req_mode(2'd2);
    pulse_fs();
    run_pixel(16'h0100, 6'd3, 6'd2, r, v, e);
    tests_run++;
    if (r !== 24'hD6D6D6) begin tests_failed++; $display("FAIL mono_grey: got %h expected d6d6d6", r); end
    run_pixel(16'h0080, 6'd0, 6'd0, r, v, e);
    tests_run++;
    if (r !== 24'h000000) begin tests_failed++; $display("FAIL mono_masked: got %h expected 000000", r); end
  endtask

  task automatic test_reset_midstream();
    logic seen;
    bus.frame = 16'h0080; bus.x = 6'd0; bus.y = 6'd0; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) step();
    tests_run++;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_valid: got %b expected 1", bus.out_valid); end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL async_reset_valid: got %b expected 0", bus.out_valid); end
    tests_run++;
    if (bus.mode !== 2'd0) begin tests_failed++; $display("FAIL async_reset_mode: got %0d expected 0", bus.mode); end
    step(); step();
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      seen = seen | bus.out_valid;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL post_reset_flush: got %b expected 0", seen); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_latency();
    test_stripes();
    test_mode_handshake();
    test_back_to_back();
    test_same_cycle();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
